clock_set_ctrl: RTL and testbench
=================================

// Module: clock_set_ctrl
// PURPOSE
//  Time-set sequencer for the HH:MM:SS counter chain on the 6-digit display.
//  Takes debounced key pulses/levels and runs a RUN/SET_HOUR/SET_MIN/SET_SEC FSM.
//  Gates the 1 Hz tick, issues per-field inc/dec pulses with hold-to-repeat,
//  and drives a per-digit blink mask to the scan stage.
// PARAMETERS
//  REPEAT_DELAY   25_000_000   hold cycles before auto-repeat starts (0.5 s @ 50 MHz)
//  REPEAT_PERIOD  5_000_000    cycles between repeated pulses while held
//  BLINK_HALF     12_500_000   cycles per blink half-phase (2 Hz blink)
//  TIMEOUT        500_000_000  idle cycles in a SET state before returning to RUN
// PORTS
//  clk        in   1  system clock
//  rst_n      in   1  async active-low reset
//  mode_p     in   1  1-cycle pulse: enter/leave set mode
//  sel_p      in   1  1-cycle pulse: next field
//  up_p       in   1  1-cycle pulse: increment selected field
//  dn_p       in   1  1-cycle pulse: decrement selected field
//  up_lvl     in   1  debounced held level of up key (active-high)
//  dn_lvl     in   1  debounced held level of down key (active-high)
//  run_en     out  1  1 = counters may advance on 1 Hz tick
//  set_active out  1  1 in any SET state
//  inc_hour   out  1  1-cycle pulse; likewise dec_hour, inc_min, dec_min, inc_sec, dec_sec
//  blink_mask out  6  1 = blank digit; [5:4] hour, [3:2] min, [1:0] sec
// BEHAVIOUR
//  Reset: state=RUN, run_en=1, set_active=0, all pulses 0, blink_mask=0, counters 0.
//  Register width: all counters 32-bit unsigned; terminal test is cnt == PARAM-1.
//  FSM transitions (evaluated per cycle):
//   RUN      --mode_p--> SET_HOUR
//   SET_HOUR --sel_p---> SET_MIN --sel_p--> SET_SEC --sel_p--> SET_HOUR
//   SET_*    --mode_p--> RUN (commit; counters keep edited values)
//  Priority: mode_p > sel_p > up/dn. mode_p and sel_p together: only mode_p acts.
//  up_p and dn_p together: both ignored, no pulse.
//  Field pulses:
//   - In SET_x, up_p/dn_p yields inc_x/dec_x exactly 1 cycle later, registered.
//   - Only the selected field pulses; pulses never occur in RUN.
//   - Pulse drives the counter's direct set input; no carry into the next field.
//  Auto-repeat:
//   - Hold counter clears on every up_p/dn_p and whenever neither level is high.
//   - While exactly one of up_lvl/dn_lvl is high:
//     - after REPEAT_DELAY cycles, one pulse;
//     - then one pulse every REPEAT_PERIOD cycles.
//   - Both levels high: counter clears, no pulses.
//  Blink:
//   - Phase counter toggles phase every BLINK_HALF cycles in SET states.
//   - Selected field's 2 bits = 1 while phase=off; all other bits 0.
//   - Any field pulse (incl. repeat) or sel_p restarts phase at "on" (digits visible).
//   - In RUN, blink_mask=0 and phase counter held at 0.
//  run_en = (state==RUN); set_active = !run_en; both registered, update the cycle after transition.
//  rst_n asserted mid-SET: immediate return to reset values, no pending pulse emitted.
// CONFIGURATION
//  CLOCK_SET_TIMEOUT_EN defined:
//   - Idle counter runs in SET states, clears on any *_p or held level.
//   - Reaching TIMEOUT forces RUN, exactly as mode_p would.
//  Undefined: no idle counter; SET states are left only by mode_p or reset.
// TESTING (bench params: REPEAT_DELAY=10, REPEAT_PERIOD=4, BLINK_HALF=8, TIMEOUT=50)
//  1. reset; mode_p; sel_p; sel_p -> states HOUR,MIN,SEC; run_en=0 from cycle after mode_p; sel_p again -> HOUR.
//  2. SET_MIN, up_p at t -> inc_min=1 at t+1 only; dn_p -> dec_min; up_p+dn_p same cycle -> no pulse.
//  3. SET_HOUR, up_lvl held 30 cycles -> inc_hour pulses at hold cycles 10,14,18,22,26,30.
//  4. SET_SEC idle -> blink_mask toggles 6'b000000/6'b000011 every 8 cycles; up_p forces 000000 for next 8.
//  5. mode_p+sel_p same cycle in SET_MIN -> RUN, run_en=1, blink_mask=0; rst_n pulse in SET_HOUR -> RUN, no pulses.
//  6. With CLOCK_SET_TIMEOUT_EN: 50 idle cycles in SET_MIN -> RUN; without the macro, still SET_MIN after 200 cycles.

Source files
------------

// File: rtl/clock_set_ctrl.sv
// Time-set sequencer for the HH:MM:SS chain: RUN/SET_HOUR/SET_MIN/SET_SEC FSM, hold-to-repeat, digit blink.
// Define CLOCK_SET_TIMEOUT_EN to return to RUN automatically after TIMEOUT idle cycles in a SET state.
module clock_set_ctrl #(
   parameter logic [31:0] REPEAT_DELAY  = 32'd25_000_000,
   parameter logic [31:0] REPEAT_PERIOD = 32'd5_000_000,
   parameter logic [31:0] BLINK_HALF    = 32'd12_500_000,
   parameter logic [31:0] TIMEOUT       = 32'd500_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       mode_p,
   input  logic       sel_p,
   input  logic       up_p,
   input  logic       dn_p,
   input  logic       up_lvl,
   input  logic       dn_lvl,
   output logic       run_en,
   output logic       set_active,
   output logic       inc_hour,
   output logic       dec_hour,
   output logic       inc_min,
   output logic       dec_min,
   output logic       inc_sec,
   output logic       dec_sec,
   output logic [5:0] blink_mask
);

   typedef enum logic [1:0] {RUN, SET_HOUR, SET_MIN, SET_SEC} state_t;

   state_t      state;
   state_t      next_state;
   logic [31:0] hold_cnt;
   logic        repeating;
   logic        hold_run;
   logic        rep_fire;
   logic        in_set;
   logic        key_ok;
   logic        step_up;
   logic        step_dn;
   logic [31:0] blink_cnt;
   logic        blink_off;
   logic        timeout;
   logic [5:0]  pulse_d;

   assign in_set   = (state != RUN);
   assign key_ok   = in_set && !mode_p && !sel_p;
   assign hold_run = in_set && !up_p && !dn_p && (up_lvl ^ dn_lvl);
   assign rep_fire = hold_run && (repeating ? (hold_cnt == REPEAT_PERIOD - 32'd1)
                                            : (hold_cnt == REPEAT_DELAY - 32'd1));
   // up_p and dn_p together cancel; a repeat follows whichever single level is held
   assign step_up  = key_ok && ((up_p && !dn_p) || (rep_fire && up_lvl));
   assign step_dn  = key_ok && ((dn_p && !up_p) || (rep_fire && dn_lvl));

`ifdef CLOCK_SET_TIMEOUT_EN
   logic [31:0] idle_cnt;
   logic        activity;

   assign activity = mode_p | sel_p | up_p | dn_p | up_lvl | dn_lvl;
   assign timeout  = in_set && !activity && (idle_cnt == TIMEOUT - 32'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         idle_cnt <= 32'd0;
      else if (!in_set || activity)
         idle_cnt <= 32'd0;
      else
         idle_cnt <= idle_cnt + 32'd1;
   end
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= RUN;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         RUN:      if (mode_p) next_state = SET_HOUR;
         SET_HOUR: if (mode_p) next_state = RUN; else if (sel_p) next_state = SET_MIN;
                   else if (timeout) next_state = RUN;
         SET_MIN:  if (mode_p) next_state = RUN; else if (sel_p) next_state = SET_SEC;
                   else if (timeout) next_state = RUN;
         SET_SEC:  if (mode_p) next_state = RUN; else if (sel_p) next_state = SET_HOUR;
                   else if (timeout) next_state = RUN;
         default:  next_state = RUN;
      endcase
   end

   always_comb begin
      pulse_d    = 6'b000000;
      blink_mask = 6'b000000;
      case (state)
         SET_HOUR: begin
            pulse_d[5:4]    = {step_up, step_dn};
            blink_mask[5:4] = {2{blink_off}};
         end
         SET_MIN: begin
            pulse_d[3:2]    = {step_up, step_dn};
            blink_mask[3:2] = {2{blink_off}};
         end
         SET_SEC: begin
            pulse_d[1:0]    = {step_up, step_dn};
            blink_mask[1:0] = {2{blink_off}};
         end
         default: ;
      endcase
   end

   // Hold counter: first run to REPEAT_DELAY, then wraps every REPEAT_PERIOD while held
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt  <= 32'd0;
         repeating <= 1'b0;
      end else if (!hold_run) begin
         hold_cnt  <= 32'd0;
         repeating <= 1'b0;
      end else if (rep_fire) begin
         hold_cnt  <= 32'd0;
         repeating <= 1'b1;
      end else begin
         hold_cnt  <= hold_cnt + 32'd1;
      end
   end

   // Any edit or field change restarts the blink with digits visible
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_cnt <= 32'd0;
         blink_off <= 1'b0;
      end else if (!in_set || next_state == RUN || step_up || step_dn || sel_p) begin
         blink_cnt <= 32'd0;
         blink_off <= 1'b0;
      end else if (blink_cnt == BLINK_HALF - 32'd1) begin
         blink_cnt <= 32'd0;
         blink_off <= ~blink_off;
      end else begin
         blink_cnt <= blink_cnt + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_en     <= 1'b1;
         set_active <= 1'b0;
         {inc_hour, dec_hour, inc_min, dec_min, inc_sec, dec_sec} <= 6'b000000;
      end else begin
         run_en     <= (next_state == RUN);
         set_active <= (next_state != RUN);
         {inc_hour, dec_hour, inc_min, dec_min, inc_sec, dec_sec} <= pulse_d;
      end
   end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: directed steps plus random key activity against a reference model.
// Build with CLOCK_SET_TIMEOUT_EN defined to exercise the idle timeout.
module tb_clock_set_ctrl;

   localparam int RD = 10;
   localparam int RP = 4;
   localparam int BH = 8;
   localparam int TO = 50;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       mode_p = 1'b0, sel_p = 1'b0, up_p = 1'b0, dn_p = 1'b0;
   logic       up_lvl = 1'b0, dn_lvl = 1'b0;
   logic       run_en, set_active;
   logic       inc_hour, dec_hour, inc_min, dec_min, inc_sec, dec_sec;
   logic [5:0] blink_mask;

   int unsigned compared = 0;
   int unsigned mismatched = 0;
   int          cyc = 0;

   // Reference model: field index (0 = RUN, 1 = hour, 2 = min, 3 = sec) and elapsed-cycle counts
   int        m_field;
   int        m_hold;
   int        m_age;
   int        m_idle;
   bit [5:0]  m_pulse;

   clock_set_ctrl #(
      .REPEAT_DELAY (32'd10),
      .REPEAT_PERIOD(32'd4),
      .BLINK_HALF   (32'd8),
      .TIMEOUT      (32'd50)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode_p    (mode_p),
      .sel_p     (sel_p),
      .up_p      (up_p),
      .dn_p      (dn_p),
      .up_lvl    (up_lvl),
      .dn_lvl    (dn_lvl),
      .run_en    (run_en),
      .set_active(set_active),
      .inc_hour  (inc_hour),
      .dec_hour  (dec_hour),
      .inc_min   (inc_min),
      .dec_min   (dec_min),
      .inc_sec   (inc_sec),
      .dec_sec   (dec_sec),
      .blink_mask(blink_mask)
   );

   always #5 clk = ~clk;

   task automatic modelReset();
      m_field = 0;
      m_hold  = 0;
      m_age   = 0;
      m_idle  = 0;
      m_pulse = '0;
   endtask

   // One clock of the specification's rules, in terms of counted hold/blink/idle cycles
   task automatic modelStep(input bit m, input bit s, input bit u, input bit d, input bit ul, input bit dl);
      bit in_set, fire, su, sd, tmo;
      int nxt;
      in_set = (m_field != 0);
      if (!in_set || u || d || !(ul ^ dl)) m_hold = 0;
      else m_hold++;
      fire = (m_hold == RD) || (m_hold > RD && ((m_hold - RD) % RP) == 0);
      su = in_set && !m && !s && ((u && !d) || (fire && ul));
      sd = in_set && !m && !s && ((d && !u) || (fire && dl));
      tmo = 1'b0;
`ifdef CLOCK_SET_TIMEOUT_EN
      if (!in_set || m || s || u || d || ul || dl) m_idle = 0;
      else m_idle++;
      tmo = (m_idle == TO);
`endif
      if (!in_set)  nxt = m ? 1 : 0;
      else if (m)   nxt = 0;
      else if (s)   nxt = (m_field % 3) + 1;
      else if (tmo) nxt = 0;
      else          nxt = m_field;
      if (!in_set || nxt == 0 || su || sd || s) m_age = 0;
      else m_age++;
      m_pulse = '0;
      if (in_set) begin
         m_pulse[(3 - m_field) * 2 + 1] = su;
         m_pulse[(3 - m_field) * 2]     = sd;
      end
      m_field = nxt;
   endtask

   function automatic logic [13:0] expectedVec();
      logic [5:0] mask;
      mask = '0;
      if (m_field != 0 && ((m_age / BH) % 2) == 1)
         mask = 6'b000011 << ((3 - m_field) * 2);
      return {(m_field == 0), (m_field != 0), m_pulse, mask};
   endfunction

   task automatic checkOutput(input string tag);
      logic [13:0] observed;
      logic [13:0] expected;
      observed = {run_en, set_active, inc_hour, dec_hour, inc_min, dec_min, inc_sec, dec_sec, blink_mask};
      expected = expectedVec();
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, observed, expected);
      end
   endtask

   task automatic applyStimulus(input bit m, input bit s, input bit u, input bit d,
                                input bit ul, input bit dl, input string tag);
      mode_p = m; sel_p = s; up_p = u; dn_p = d; up_lvl = ul; dn_lvl = dl;
      modelStep(m, s, u, d, ul, dl);
      @(posedge clk);
      #1;
      cyc++;
      checkOutput(tag);
   endtask

   task automatic idleCycles(input int n, input bit ul, input bit dl, input string tag);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, ul, dl, tag);
   endtask

   initial begin
      bit r_ul, r_dl;
      modelReset();
      #1 rst_n = 1'b0;
      #2 checkOutput("reset_state");
      @(negedge clk) rst_n = 1'b1;
      idleCycles(2, 0, 0, "run_idle");

      // Field walk: HOUR -> MIN -> SEC -> HOUR, idling long enough to see each field blink
      applyStimulus(1, 0, 0, 0, 0, 0, "mode_enter");
      idleCycles(BH + 2, 0, 0, "hour_blink");
      applyStimulus(0, 1, 0, 0, 0, 0, "sel_min");
      idleCycles(BH + 2, 0, 0, "min_blink");
      applyStimulus(0, 1, 0, 0, 0, 0, "sel_sec");
      idleCycles(BH + 2, 0, 0, "sec_blink");
      applyStimulus(0, 1, 0, 0, 0, 0, "sel_wrap_hour");
      idleCycles(BH + 2, 0, 0, "hour_again");

      // Single-step pulses in SET_MIN, including the cancelling up+dn case
      applyStimulus(0, 1, 0, 0, 0, 0, "sel_min2");
      applyStimulus(0, 0, 1, 0, 0, 0, "up_min");
      idleCycles($urandom_range(1, 4), 0, 0, "after_up");
      applyStimulus(0, 0, 0, 1, 0, 0, "dn_min");
      idleCycles($urandom_range(1, 4), 0, 0, "after_dn");
      applyStimulus(0, 0, 1, 1, 0, 0, "up_dn_both");
      idleCycles(3, 0, 0, "after_both");

      // Hold-to-repeat in SET_HOUR
      applyStimulus(0, 1, 0, 0, 0, 0, "sel_sec2");
      applyStimulus(0, 1, 0, 0, 0, 0, "sel_hour2");
      idleCycles(30, 1, 0, "hold_up");
      idleCycles(3, 0, 0, "release_up");
      idleCycles($urandom_range(12, 25), 0, 1, "hold_dn");
      idleCycles(15, 1, 1, "hold_both");
      idleCycles(2, 0, 0, "release_both");

      // Blink restart on edit in SET_SEC
      applyStimulus(0, 1, 0, 0, 0, 0, "sel_min3");
      applyStimulus(0, 1, 0, 0, 0, 0, "sel_sec3");
      idleCycles(20, 0, 0, "sec_idle");
      applyStimulus(0, 0, 1, 0, 0, 0, "sec_up");
      idleCycles(12, 0, 0, "sec_restart");

      // mode_p wins over sel_p; nothing pulses in RUN
      applyStimulus(0, 1, 0, 0, 0, 0, "sel_hour3");
      applyStimulus(0, 1, 0, 0, 0, 0, "sel_min4");
      applyStimulus(1, 1, 0, 0, 0, 0, "mode_sel_both");
      idleCycles(3, 0, 0, "run_after_commit");
      applyStimulus(0, 0, 1, 0, 0, 0, "run_up_p");
      idleCycles(15, 1, 0, "run_hold_up");

      // Asynchronous reset with an up_p in flight
      applyStimulus(1, 0, 0, 0, 0, 0, "enter_hour_rst");
      up_p = 1'b1;
      #2 rst_n = 1'b0;
      modelReset();
      #1 checkOutput("rst_async");
      @(posedge clk);
      #1 checkOutput("rst_held");
      up_p = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      idleCycles(2, 0, 0, "post_rst");

      // Long idle in SET_MIN: leaves for RUN only when the timeout is built in
      applyStimulus(1, 0, 0, 0, 0, 0, "mode_enter2");
      applyStimulus(0, 1, 0, 0, 0, 0, "sel_min5");
      idleCycles(200, 0, 0, "long_idle");

      // Random key activity
      r_ul = 1'b0;
      r_dl = 1'b0;
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 14) == 0) r_ul = ~r_ul;
         if ($urandom_range(0, 14) == 0) r_dl = ~r_dl;
         applyStimulus(($urandom_range(0, 39) == 0), ($urandom_range(0, 11) == 0),
                       ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                       r_ul, r_dl, "random");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
